fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end between the instruction memory and the CPU datapath. The datapath drives its word-aligned instruction address IA each cycle; this block returns the matching instruction word ID with a valid flag from a two-entry instruction buffer. On a miss it issues a request/grant/response transaction to instruction memory. The control unit stalls PC update and register writes while ID_valid is low.

## Interface
- No parameters.
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- flush  in  1  invalidate buffer; driven by the datapath RESET.
- IA  in  32  instruction address from the datapath; IA[1:0] ignored.
- ID  out  32  instruction word for IA; 0 when ID_valid=0 or on a fault.
- ID_valid  out  1  ID corresponds to the current IA.
- ID_fault  out  1  the hit entry was filled with a memory error; the control unit takes Illop.
- imem_req  out  1  memory request, held until granted.
- imem_addr  out  32  request address {tag, 2'b00}; stable while imem_req=1.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; exactly one per grant, at least 1 cycle after the grant.
- imem_rdata  in  32  response data.
- imem_err  in  1  response error, qualified by imem_rvalid.

## Operation
- Two entries E0/E1, each holding {valid, tag[29:0], data[31:0], fault}. Hit when an entry is valid and its tag equals IA[31:2]. Lookup is combinational: ID, ID_valid and ID_fault are driven from the hit entry in the same cycle.
- FSM states:
  - IDLE: on a demand miss with flush=0, latch imem_addr={IA[31:2],2'b00} and go to REQ.
  - REQ: imem_req=1. On imem_gnt go to WAIT, or to DROP if flush has been seen since the request was latched.
  - WAIT: on imem_rvalid, fill the victim entry with data and error→fault, then return to IDLE.
  - DROP: on imem_rvalid, discard the response and return to IDLE.
- A request is never withdrawn. A flush in REQ or WAIT marks the outstanding response for discard: it completes the handshake, then discards the data.
- Victim selection: a victim pointer toggles on every fill. If the victim entry is valid and matches the current IA, the other entry is filled instead.
- If IA changes while a request is in flight, the response still fills an entry. Lookup is re-evaluated on return.
- flush clears all valid bits at the next edge. If flush and a fill would land on the same edge, flush wins.
- Reset: state IDLE, entries invalid, victim pointer 0, imem_req=0, imem_addr=0. Consequently ID=0, ID_valid=0, ID_fault=0.

## Timing
- Hit: 0-cycle latency; ID_valid is asserted in the same cycle IA is presented.
- Miss with IA presented at cycle t: imem_req rises at t+1. With an immediate grant and rvalid at t+2, the entry is written at the end of t+2 and ID_valid=1 at t+3. Minimum miss latency is 3 cycles.
- Each extra grant or response wait cycle adds one cycle of latency.
- At most one outstanding transaction at any time.

## Configuration
- FETCH_PREFETCH_EN defined:
  - In IDLE with a demand hit, if IA+4 is in neither entry, issue a request for IA+4.
  - The prefetch fills the entry not matching IA.
  - No prefetch when IA[30:2] is all ones; a prefetch never crosses the supervisor bit IA[31] and never wraps.
  - A demand miss always takes priority over a prefetch; an in-flight prefetch is not cancelled by a miss.
- Undefined: only demand misses generate requests.

## Test plan
- Reset, then IA=0x80000000, grant immediately, rvalid next cycle with rdata=0x77FF0000 → imem_req=1 with imem_addr=0x80000000 at cycle 1, ID_valid=1 and ID=0x77FF0000 at cycle 3.
- Macro off, IA held at 0x80000000 for 10 cycles after the fill → ID_valid=1 throughout, imem_req stays 0.
- Macro on, after the first fill → request to 0x80000004 issued. Once that fill completes, IA=0x80000004 → ID_valid=1 in the same cycle.
- Flush in WAIT, then rvalid with rdata=0xDEADBEEF → data discarded, ID_valid=0, a new request for IA issues after the drain.
- rvalid with imem_err=1 for IA=0x80000010 → ID_valid=1, ID_fault=1, ID=0.
- Macro on, IA=0x7FFFFFFC resident → no prefetch request (imem_req stays 0).

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - two-entry instruction buffer with req/gnt/rvalid memory miss path
// Optional next-line prefetch is built when FETCH_PREFETCH_EN is defined.
`timescale 1ns/1ps

module fetch_unit (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        flush,
  input  logic [31:0] IA,
  output logic [31:0] ID,
  output logic        ID_valid,
  output logic        ID_fault,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic        vp_q;
  logic [1:0]  valid_q;
  logic [29:0] tag_q   [0:1];
  logic [31:0] data_q  [0:1];
  logic [1:0]  fault_q;

  logic [29:0] ia_tag;
  logic        hit0, hit1, hit, hit_idx;
  logic        fill_en, fill_idx;
  logic        pf_go;
  logic [29:0] pf_tag;
  logic        ia_lsb_unused;

  assign ia_tag        = IA[31:2];
  assign ia_lsb_unused = ^IA[1:0];

  assign hit0    = valid_q[0] && (tag_q[0] == ia_tag);
  assign hit1    = valid_q[1] && (tag_q[1] == ia_tag);
  assign hit     = hit0 || hit1;
  assign hit_idx = hit0 ? 1'b0 : 1'b1;

  assign ID_valid = hit;
  assign ID_fault = hit && fault_q[hit_idx];
  assign ID       = (hit && !fault_q[hit_idx]) ? data_q[hit_idx] : 32'h0;

  // Never evict the entry the datapath is currently reading from.
  assign fill_idx = (valid_q[vp_q] && (tag_q[vp_q] == ia_tag)) ? ~vp_q : vp_q;

`ifdef FETCH_PREFETCH_EN
  logic pf_present;
  // Bit 31 is carried through untouched so a prefetch never leaves its privilege half.
  assign pf_tag     = {IA[31], IA[30:2] + 29'd1};
  assign pf_present = (valid_q[0] && (tag_q[0] == pf_tag)) ||
                      (valid_q[1] && (tag_q[1] == pf_tag));
  assign pf_go      = hit && !pf_present && (IA[30:2] != 29'h1FFF_FFFF);
`else
  assign pf_tag = 30'h0;
  assign pf_go  = 1'b0;
`endif

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    fill_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (!hit) begin
            addr_d  = {ia_tag, 2'b00};
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (pf_go) begin
            addr_d  = {pf_tag, 2'b00};
            drop_d  = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          drop_d = 1'b1;
        end
        if (imem_gnt) begin
          state_d = (drop_q || flush) ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        // A flush landing with the response discards it.
        if (imem_rvalid) begin
          fill_en = !flush;
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vp_q      <= 1'b0;
      valid_q   <= 2'b00;
      fault_q   <= 2'b00;
      tag_q[0]  <= 30'h0;
      tag_q[1]  <= 30'h0;
      data_q[0] <= 32'h0;
      data_q[1] <= 32'h0;
    end else if (flush) begin
      valid_q <= 2'b00;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      tag_q[fill_idx]   <= addr_q[31:2];
      data_q[fill_idx]  <= imem_rdata;
      fault_q[fill_idx] <= imem_err;
      vp_q              <= ~vp_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
`timescale 1ns/1ps

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        flush;
  logic [31:0] IA;
  logic [31:0] ID;
  logic        ID_valid;
  logic        ID_fault;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .flush       (flush),
    .IA          (IA),
    .ID          (ID),
    .ID_valid    (ID_valid),
    .ID_fault    (ID_fault),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return ^a[5:2];
  endfunction

  task automatic do_reset();
    n_rst = 1'b0; flush = 1'b0; IA = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Runs a miss for the IA already driven: grant at cycle 1, response at cycle 2; returns in cycle 3.
  task automatic fill_now(input logic [31:0] data, input logic err);
    next_cycle();
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data; imem_err = err;
    next_cycle();
    imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", ID_valid); end
    checks++; if (ID !== 32'h0) begin errors++; $display("FAIL reset_id: got %h expected 0", ID); end
    checks++; if (ID_fault !== 1'b0) begin errors++; $display("FAIL reset_id_fault: got %b expected 0", ID_fault); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_first_fill();
    do_reset();
    IA = 32'h8000_0000;
    settle();
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL ff_c0_valid: got %b expected 0", ID_valid); end
    next_cycle(); settle();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ff_c1_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL ff_c1_addr: got %h expected 80000000", imem_addr); end
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h77FF_0000;
    settle();
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL ff_c2_valid: got %b expected 0", ID_valid); end
    next_cycle();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    settle();
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL ff_c3_valid: got %b expected 1", ID_valid); end
    checks++; if (ID !== 32'h77FF_0000) begin errors++; $display("FAIL ff_c3_id: got %h expected 77ff0000", ID); end
    checks++; if (ID_fault !== 1'b0) begin errors++; $display("FAIL ff_c3_fault: got %b expected 0", ID_fault); end
  endtask

`ifdef FETCH_PREFETCH_EN
  task automatic test_prefetch();
    do_reset();
    IA = 32'h8000_0000;
    fill_now(32'h77FF_0000, 1'b0);
    settle();
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL pf_c3_valid: got %b expected 1", ID_valid); end
    next_cycle(); settle();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL pf_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL pf_addr: got %h expected 80000004", imem_addr); end
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0004;
    next_cycle();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    IA = 32'h8000_0004;
    settle();
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL pf_hit_valid: got %b expected 1", ID_valid); end
    checks++; if (ID !== 32'hCAFE_0004) begin errors++; $display("FAIL pf_hit_id: got %h expected cafe0004", ID); end
  endtask
`else
  task automatic test_hold();
    do_reset();
    IA = 32'h8000_0000;
    fill_now(32'h77FF_0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, ID_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %b expected 0", i, imem_req); end
      next_cycle();
    end
  endtask
`endif

  task automatic test_flush_drop();
    do_reset();
    IA = 32'h8000_0020;
    next_cycle();
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0; flush = 1'b1;
    next_cycle();
    flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    settle();
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL fd_c3_valid: got %b expected 0", ID_valid); end
    next_cycle();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    settle();
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL fd_c4_valid: got %b expected 0", ID_valid); end
    checks++; if (ID !== 32'h0) begin errors++; $display("FAIL fd_c4_id: got %h expected 0", ID); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fd_c4_req: got %b expected 0", imem_req); end
    next_cycle(); settle();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fd_c5_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h8000_0020) begin errors++; $display("FAIL fd_c5_addr: got %h expected 80000020", imem_addr); end
  endtask

  task automatic test_fault();
    do_reset();
    IA = 32'h8000_0010;
    fill_now(32'h1234_5678, 1'b1);
    settle();
    checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL fault_valid: got %b expected 1", ID_valid); end
    checks++; if (ID_fault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b expected 1", ID_fault); end
    checks++; if (ID !== 32'h0) begin errors++; $display("FAIL fault_id: got %h expected 0", ID); end
  endtask

  task automatic test_no_prefetch_boundary();
    do_reset();
    IA = 32'h7FFF_FFFC;
    fill_now(32'h0BAD_F00D, 1'b0);
    for (int i = 0; i < 6; i++) begin
      settle();
      checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL bnd_valid[%0d]: got %b expected 1", i, ID_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bnd_req[%0d]: got %b expected 0", i, imem_req); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [7];
    logic        pending, prev_req, prev_gnt, prev_flush, was_pending, pf_ok;
    logic [31:0] paddr, prev_addr, prev_ia, exp_word;
    int          cnt, req_wait, hold, since;
    pool = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h0000_1000,
             32'h7FFF_FFFC, 32'hFFFF_FFFC, 32'h8000_0010};
    pending = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0; prev_flush = 1'b0;
    paddr = 32'h0; prev_addr = 32'h0; prev_ia = 32'h0;
    cnt = 0; req_wait = 0; hold = 0; since = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      was_pending = pending;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      imem_err    = 1'($urandom_range(0, 1));
      if (pending) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          imem_err    = mem_err(paddr);
          pending     = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req) begin
        checks++; if (was_pending) begin errors++; $display("FAIL rnd_outstanding[%0d]: got req=1 expected 0 while response pending", c); end
      end
      if (imem_req && prev_req && !prev_gnt) begin
        checks++; if (imem_addr !== prev_addr) begin errors++; $display("FAIL rnd_addr_stable[%0d]: got %h expected %h", c, imem_addr, prev_addr); end
      end
      if (imem_req && !prev_req) begin
`ifdef FETCH_PREFETCH_EN
        pf_ok = (prev_ia[30:2] != 29'h1FFF_FFFF) && (imem_addr == ({prev_ia[31:2], 2'b00} + 32'd4));
`else
        pf_ok = 1'b0;
`endif
        checks++;
        if (imem_addr !== {prev_ia[31:2], 2'b00} && !pf_ok) begin
          errors++; $display("FAIL rnd_req_addr[%0d]: got %h expected %h", c, imem_addr, {prev_ia[31:2], 2'b00});
        end
      end
      imem_gnt = 1'b0;
      if (imem_req) begin
        req_wait++;
        if (req_wait > 3 || $urandom_range(0, 1) == 1) begin
          imem_gnt = 1'b1;
          pending  = 1'b1;
          cnt      = $urandom_range(0, 3);
          paddr    = imem_addr;
          req_wait = 0;
        end
      end
      if (hold == 0) begin
        IA    = pool[$urandom_range(0, 6)];
        hold  = $urandom_range(1, 40);
        since = 0;
      end
      hold--;
      flush = ($urandom_range(0, 49) == 0);
      settle();
      if (prev_flush) begin
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL rnd_after_flush[%0d]: got valid=%b expected 0", c, ID_valid); end
      end
      exp_word = mem_err(IA) ? 32'h0 : mem_word(IA);
      checks++;
      if (ID_valid === 1'b1) begin
        if (ID !== exp_word || ID_fault !== mem_err(IA)) begin
          errors++; $display("FAIL rnd_data[%0d]: got %h/%b expected %h/%b for IA %h", c, ID, ID_fault, exp_word, mem_err(IA), IA);
        end
      end else if (ID !== 32'h0 || ID_fault !== 1'b0) begin
        errors++; $display("FAIL rnd_idle_out[%0d]: got %h/%b expected 0/0", c, ID, ID_fault);
      end
      if (since >= 30) begin
        checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL rnd_timeout[%0d]: got valid=%b expected 1 for IA %h", c, ID_valid, IA); end
      end
      since      = flush ? 0 : since + 1;
      prev_flush = flush;
      prev_req   = imem_req;
      prev_gnt   = imem_gnt;
      prev_addr  = imem_addr;
      prev_ia    = IA;
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_first_fill();
`ifdef FETCH_PREFETCH_EN
    test_prefetch();
`else
    test_hold();
`endif
    test_flush_drop();
    test_fault();
    test_no_prefetch_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach summary within time limit");
    $fatal(1);
  end

endmodule
